// File: rtl/icache_direct_if.sv
// Fetch-side (imemREN/imemaddr -> ihit/imemload) and memory-side (iREN/iaddr <- iwait/iload) bundle.
// slave = cache view, master = datapath/memory-controller view.
interface icache_direct_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        inv;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   modport slave (
      input  imemREN, imemaddr, inv, iwait, iload,
      output ihit, imemload, iREN, iaddr, hit_cnt, miss_cnt
   );

   modport master (
      output imemREN, imemaddr, inv, iwait, iload,
      input  ihit, imemload, iREN, iaddr, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped 1-word-block icache: hits combinational (0 cycles), misses 1 + wait + 1 cycles; fetch stalls while ihit=0.
// Memory backpressure via iwait holds FILL; ICACHE_PERF_EN adds hit/miss counters (else tied to 0).
module icache_direct #(
   parameter int SETS     = 16,
   parameter int PC_RANGE = 32
) (
   input  logic            CLK,
   input  logic            nRST,
   icache_direct_if.slave  cif
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = PC_RANGE - IDX_W - 2;

   localparam logic [0:0] COMPARE = 1'b0;
   localparam logic [0:0] FILL    = 1'b1;

   logic [0:0]             state;
   logic [SETS-1:0]        valid;
   logic [TAG_W-1:0]       tag_arr  [SETS];
   logic [31:0]            data_arr [SETS];
   logic [TAG_W+IDX_W-1:0] miss_addr;

   logic [IDX_W-1:0]       idx;
   logic [TAG_W-1:0]       tag;
   logic [IDX_W-1:0]       fill_idx;
   logic [TAG_W-1:0]       fill_tag;
   logic                   hit;
   logic                   miss_start;
   logic                   fill_done;
   logic                   unused_addr_bits;

   assign idx      = cif.imemaddr[IDX_W+1:2];
   assign tag      = cif.imemaddr[PC_RANGE-1:IDX_W+2];
   assign fill_idx = miss_addr[IDX_W-1:0];
   assign fill_tag = miss_addr[TAG_W+IDX_W-1:IDX_W];
   assign unused_addr_bits = ^cif.imemaddr[1:0];

   assign hit        = (state == COMPARE) && cif.imemREN && valid[idx] && (tag_arr[idx] == tag);
   assign miss_start = (state == COMPARE) && cif.imemREN && !hit;
   assign fill_done  = (state == FILL) && !cif.iwait;

   assign cif.ihit     = hit;
   assign cif.imemload = hit ? data_arr[idx] : '0;
   assign cif.iREN     = (state == FILL);
   assign cif.iaddr    = (state == FILL) ? 32'({miss_addr, 2'b00}) : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= COMPARE;
         valid     <= '0;
         miss_addr <= '0;
      end else begin
         if (cif.inv)
            valid <= '0;
         case (state)
            COMPARE: begin
               if (miss_start) begin
                  miss_addr <= {tag, idx};
                  state     <= FILL;
               end
            end
            default: begin
               // Written after the inv clear so an in-flight fill survives an invalidate.
               if (fill_done) begin
                  valid[fill_idx] <= 1'b1;
                  state           <= COMPARE;
               end
            end
         endcase
      end
   end

   // Tag/data need no reset: a frame is only read once its valid bit is set.
   always_ff @(posedge CLK) begin
      if (fill_done) begin
         tag_arr[fill_idx]  <= fill_tag;
         data_arr[fill_idx] <= cif.iload;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (cif.inv) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (hit)
            hit_q <= hit_q + 32'd1;
         if (miss_start)
            miss_q <= miss_q + 32'd1;
      end
   end

   assign cif.hit_cnt  = hit_q;
   assign cif.miss_cnt = miss_q;
`else
   assign cif.hit_cnt  = '0;
   assign cif.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: stimulus queues expected fill addresses and hit data,
// a memory responder and a hit monitor pop and compare as the DUT presents them.
module tb_icache_direct;
   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   icache_direct_if cif();

   icache_direct #(.SETS(16), .PC_RANGE(32)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .cif  (cif)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] hitq[$];
   logic [31:0] fillq[$];
   int mem_lat  = 0;
   int busy     = 0;
   int fill_len = 0;

`ifdef ICACHE_PERF_EN
   localparam logic [31:0] EXP_HITS_T2   = 32'd2;
   localparam logic [31:0] EXP_MISSES_T2 = 32'd1;
`else
   localparam logic [31:0] EXP_HITS_T2   = 32'd0;
   localparam logic [31:0] EXP_MISSES_T2 = 32'd0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      n_checks++;
      $display("FAIL %s: got 0x%08h, expected no such event", name, act);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      case (a & 32'hFFFF_FFFC)
         32'h0000_0040: w = 32'h2001_0005;
         32'h0000_0080: w = 32'h8C22_0004;
         32'h0000_0044: w = 32'h3C01_1234;
         32'h0000_0048: w = 32'h0000_0020;
         32'h0000_004C: w = 32'hAC41_0008;
         default:       w = 32'hDEAD_BEEF;
      endcase
      return w;
   endfunction

   // Memory controller model: answers after mem_lat busy cycles, checks each accepted fill address.
   always @(negedge CLK) begin
      if (nRST && cif.iREN) begin
         if (busy >= mem_lat) begin
            if (fillq.size() == 0) fail("unexpected_fill", cif.iaddr);
            else check("fill_addr", cif.iaddr, fillq.pop_front());
            fill_len  = busy + 1;
            busy      = 0;
            cif.iwait = 1'b0;
            cif.iload = mem_word(cif.iaddr);
         end else begin
            busy++;
            cif.iwait = 1'b1;
         end
      end else begin
         busy      = 0;
         cif.iwait = 1'b1;
         cif.iload = 32'h0;
      end
   end

   // Fetch-side monitor.
   always @(negedge CLK) begin
      if (nRST) begin
         if (cif.ihit) begin
            if (hitq.size() == 0) fail("unexpected_hit", cif.imemload);
            else check("imemload", cif.imemload, hitq.pop_front());
         end else begin
            check("imemload_zero_no_hit", cif.imemload, 32'h0);
         end
      end
   end

   task automatic wait_hit(input int exp_cyc);
      int cyc = 0;
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge CLK);
         if (cif.ihit) got = 1'b1;
         else begin
            cyc++;
            @(posedge CLK); #1;
         end
      end
      if (!got) fail("hit_timeout", 32'(cyc));
      else check("stall_cycles", 32'(cyc), 32'(exp_cyc));
      @(posedge CLK); #1;
      cif.imemREN = 1'b0;
   endtask

   task automatic read(input logic [31:0] a, input bit miss, input int lat);
      mem_lat = lat;
      hitq.push_back(mem_word(a));
      if (miss) fillq.push_back(a);
      cif.imemREN  = 1'b1;
      cif.imemaddr = a;
      wait_hit(miss ? lat + 2 : 0);
   endtask

   initial begin
      nRST = 1'b0;
      cif.imemREN  = 1'b0;
      cif.imemaddr = 32'h0;
      cif.inv      = 1'b0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;

      // Reset state
      @(negedge CLK);
      check("rst_ihit", {31'h0, cif.ihit}, 32'h0);
      check("rst_iREN", {31'h0, cif.iREN}, 32'h0);
      check("rst_iaddr", cif.iaddr, 32'h0);
      check("rst_hit_cnt", cif.hit_cnt, 32'h0);
      check("rst_miss_cnt", cif.miss_cnt, 32'h0);
      @(posedge CLK); #1;

      // Cold miss with two wait cycles, then hit
      read(32'h40, 1'b1, 2);
      check("cold_fill_len", 32'(fill_len), 32'd3);
      read(32'h40, 1'b0, 0);
      check("t2_hit_cnt", cif.hit_cnt, EXP_HITS_T2);
      check("t2_miss_cnt", cif.miss_cnt, EXP_MISSES_T2);

      // Conflict eviction on idx 0
      read(32'h80, 1'b1, 0);
      check("zero_wait_fill_len", 32'(fill_len), 32'd1);
      read(32'h40, 1'b1, 0);
      read(32'h40, 1'b0, 0);

      // Invalidate in COMPARE
      cif.inv = 1'b1;
      @(posedge CLK); #1;
      cif.inv = 1'b0;
      @(negedge CLK);
      check("inv_hit_cnt", cif.hit_cnt, 32'h0);
      check("inv_miss_cnt", cif.miss_cnt, 32'h0);
      @(posedge CLK); #1;
      read(32'h40, 1'b1, 1);

      // Invalidate during FILL: the in-flight frame still becomes valid
      mem_lat = 3;
      fillq.push_back(32'h4C);
      hitq.push_back(mem_word(32'h4C));
      cif.imemREN  = 1'b1;
      cif.imemaddr = 32'h4C;
      @(posedge CLK); #1;
      cif.inv = 1'b1;
      @(posedge CLK); #1;
      cif.inv = 1'b0;
      wait_hit(3);
      read(32'h4C, 1'b0, 0);
      read(32'h40, 1'b1, 0);

      // Address change mid-fill: 0x44 completes, then 0x48 misses
      mem_lat = 3;
      fillq.push_back(32'h44);
      fillq.push_back(32'h48);
      hitq.push_back(mem_word(32'h48));
      cif.imemREN  = 1'b1;
      cif.imemaddr = 32'h44;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      cif.imemaddr = 32'h48;
      wait_hit(8);
      read(32'h44, 1'b0, 0);
      read(32'h48, 1'b0, 0);

      // Async reset during FILL
      read(32'h40, 1'b0, 0);
      mem_lat = 20;
      cif.imemREN  = 1'b1;
      cif.imemaddr = 32'h50;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("pre_rst_iREN", {31'h0, cif.iREN}, 32'h1);
      #2 nRST = 1'b0;
      #1;
      check("async_rst_iREN", {31'h0, cif.iREN}, 32'h0);
      check("async_rst_iaddr", cif.iaddr, 32'h0);
      cif.imemREN = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      read(32'h40, 1'b1, 0);

      check("hitq_drained", 32'(hitq.size()), 32'h0);
      check("fillq_drained", 32'(fillq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
